// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- bundle between the pipeline datapath and its controller.
//   Datapath -> controller : is_hazard, is_branch_fault, is_hit, pc_out, restart
//   Controller -> datapath : load_pc, load_latch, nop_latch
//   Controller status      : state, done, miss_timeout, stall_cnt, flush_cnt
// Modports:
//   slave  : the controller (pipe_ctrl) side
//   master : the datapath / environment side
interface pipe_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5,
    parameter int CNT_W  = 16
);
    logic                is_hazard;
    logic                is_branch_fault;
    logic                is_hit;
    logic [WIDTH-1:0]    pc_out;
    logic                restart;

    logic                load_pc;
    logic [STAGES-2:0]   load_latch;
    logic [STAGES-2:0]   nop_latch;
    logic [1:0]          state;
    logic                done;
    logic                miss_timeout;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport slave (
        input  is_hazard, is_branch_fault, is_hit, pc_out, restart,
        output load_pc, load_latch, nop_latch, state, done, miss_timeout,
               stall_cnt, flush_cnt
    );

    modport master (
        output is_hazard, is_branch_fault, is_hit, pc_out, restart,
        input  load_pc, load_latch, nop_latch, state, done, miss_timeout,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / miss / drain controller.
// Decodes every cycle one of FLUSH, FREEZE, BUBBLE, ADVANCE or a drain step
// into PC / pipeline-latch enables and bubble injects, and tracks a small FSM
// (RUN, MISS, DRAIN, HALT) plus saturating stall and flush counters.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_ctrl_if.slave (hazard/fault/hit/pc/restart in;
//            load_pc, load_latch, nop_latch, state, done, miss_timeout,
//            stall_cnt, flush_cnt out)
module pipe_ctrl #(
    parameter int WIDTH         = 32,
    parameter int INSTR_NUMBERS = 16,
    parameter int STAGES        = 5,
    parameter int HAZ_IDX       = 1,
    parameter int FLUSH_DEPTH   = 3,
    parameter int CNT_W         = 16,
    parameter int MISS_LIMIT    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_ctrl_if.slave    bus
);
    localparam int NL   = STAGES - 1;
    localparam int DW   = $clog2(STAGES);
    localparam int MR_W = $clog2(MISS_LIMIT + 1);

    localparam logic [WIDTH-1:0] PC_END     = WIDTH'(INSTR_NUMBERS);
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(STAGES - 2);
    localparam logic [MR_W-1:0]  MISS_MAX   = MR_W'(MISS_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ADVANCE,
        ACT_DRAIN
    } act_t;

    // Constant per-latch masks for the flush and bubble decodes.
    logic [NL-1:0] flush_nop_mask;
    logic [NL-1:0] bubble_load_mask;
    logic [NL-1:0] bubble_nop_mask;

    for (genvar gi = 0; gi < NL; gi++) begin : g_mask
        assign flush_nop_mask[gi]   = (gi < FLUSH_DEPTH);
        assign bubble_load_mask[gi] = (gi >= HAZ_IDX);
        assign bubble_nop_mask[gi]  = (gi == HAZ_IDX);
    end

    state_t            state_reg, state_next;
    logic [DW-1:0]     drain_cnt_reg, drain_cnt_next;
    logic [MR_W-1:0]   miss_run_reg, miss_run_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;
    logic              done_reg, done_next;
    logic              miss_timeout_reg, miss_timeout_next;

    act_t              act;
    logic              pc_in_range;
    logic [MR_W-1:0]   miss_run_inc;
    logic              load_pc_dec;
    logic [NL-1:0]     load_latch_dec;
    logic [NL-1:0]     nop_latch_dec;

    assign pc_in_range  = (bus.pc_out < PC_END);
    assign miss_run_inc = miss_run_reg + 1'b1;

    // Next-state and action selection.
    always_comb begin
        state_next        = state_reg;
        drain_cnt_next    = drain_cnt_reg;
        miss_run_next     = miss_run_reg;
        done_next         = done_reg;
        miss_timeout_next = miss_timeout_reg;
        act               = ACT_IDLE;

        unique case (state_reg)
            RUN, MISS: begin
                if (bus.is_branch_fault) begin
                    act        = ACT_FLUSH;
                    state_next = RUN;
                end else if (!bus.is_hit) begin
                    act = ACT_FREEZE;
                    if (state_reg == RUN) begin
                        state_next    = MISS;
                        miss_run_next = MR_W'(1);
                    end else begin
                        miss_run_next = miss_run_inc;
                        if (miss_run_inc >= MISS_MAX) begin
                            miss_timeout_next = 1'b1;
                            done_next         = 1'b1;
                            state_next        = HALT;
                        end
                    end
                end else if (bus.is_hazard) begin
                    act        = ACT_BUBBLE;
                    state_next = RUN;
                end else begin
                    act        = ACT_ADVANCE;
                    state_next = RUN;
                    // Fetch ran past the program end: start draining.
                    if (!pc_in_range) begin
                        drain_cnt_next = DRAIN_INIT;
                        state_next     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.is_branch_fault) begin
                    act        = ACT_FLUSH;
                    state_next = RUN;
                end else if (bus.is_hazard) begin
                    act = ACT_BUBBLE;
                end else begin
                    act = ACT_DRAIN;
                    if (drain_cnt_reg == '0) begin
                        state_next = HALT;
                        done_next  = 1'b1;
                    end else begin
                        drain_cnt_next = drain_cnt_reg - 1'b1;
                    end
                end
            end
            HALT: begin
                act = ACT_IDLE;
                if (bus.restart) begin
                    state_next        = RUN;
                    done_next         = 1'b0;
                    miss_timeout_next = 1'b0;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Output decode of the selected action, plus counter updates.
    always_comb begin
        load_pc_dec    = 1'b0;
        load_latch_dec = '0;
        nop_latch_dec  = '0;

        unique case (act)
            ACT_FLUSH: begin
                load_pc_dec    = 1'b1;
                load_latch_dec = '1;
                nop_latch_dec  = flush_nop_mask;
            end
            ACT_BUBBLE: begin
                load_latch_dec = bubble_load_mask;
                nop_latch_dec  = bubble_nop_mask;
            end
            ACT_ADVANCE: begin
                load_pc_dec      = pc_in_range;
                load_latch_dec   = '1;
                nop_latch_dec[0] = !pc_in_range;
            end
            ACT_DRAIN: begin
                load_latch_dec   = '1;
                nop_latch_dec[0] = 1'b1;
            end
            default: begin
                load_pc_dec = 1'b0;
            end
        endcase

        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if ((act == ACT_FREEZE || act == ACT_BUBBLE) && stall_cnt_reg != CNT_MAX)
            stall_cnt_next = stall_cnt_reg + 1'b1;
        if (act == ACT_FLUSH && flush_cnt_reg != CNT_MAX)
            flush_cnt_next = flush_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= RUN;
            drain_cnt_reg    <= '0;
            miss_run_reg     <= '0;
            stall_cnt_reg    <= '0;
            flush_cnt_reg    <= '0;
            done_reg         <= 1'b0;
            miss_timeout_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            drain_cnt_reg    <= drain_cnt_next;
            miss_run_reg     <= miss_run_next;
            stall_cnt_reg    <= stall_cnt_next;
            flush_cnt_reg    <= flush_cnt_next;
            done_reg         <= done_next;
            miss_timeout_reg <= miss_timeout_next;
        end
    end

    // Enables must drop the instant reset asserts, not at the next edge.
    assign bus.load_pc      = rst_n & load_pc_dec;
    assign bus.load_latch   = rst_n ? load_latch_dec : '0;
    assign bus.nop_latch    = rst_n ? nop_latch_dec : '0;
    assign bus.state        = state_reg;
    assign bus.done         = done_reg;
    assign bus.miss_timeout = miss_timeout_reg;
    assign bus.stall_cnt    = stall_cnt_reg;
    assign bus.flush_cnt    = flush_cnt_reg;
endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    localparam int WIDTH         = 32;
    localparam int INSTR_NUMBERS = 16;
    localparam int STAGES        = 5;
    localparam int HAZ_IDX       = 1;
    localparam int FLUSH_DEPTH   = 3;
    localparam int CNT_W         = 16;
    localparam int MISS_LIMIT    = 64;
    localparam int NL            = STAGES - 1;
    localparam int ALL_L         = (1 << NL) - 1;
    localparam int CMAX          = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) bus ();
    pipe_ctrl_if #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(4))     bus4 ();

    pipe_ctrl #(
        .WIDTH(WIDTH), .INSTR_NUMBERS(INSTR_NUMBERS), .STAGES(STAGES),
        .HAZ_IDX(HAZ_IDX), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W),
        .MISS_LIMIT(MISS_LIMIT)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    pipe_ctrl #(
        .WIDTH(WIDTH), .INSTR_NUMBERS(INSTR_NUMBERS), .STAGES(STAGES),
        .HAZ_IDX(HAZ_IDX), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(4),
        .MISS_LIMIT(MISS_LIMIT)
    ) u_dut4 (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: modes 0=RUN 1=MISS 2=DRAIN 3=HALT.
    int m_state, m_drain, m_miss, m_stall, m_flush, m_done, m_to;

    task automatic model_reset();
        m_state = 0; m_drain = 0; m_miss = 0;
        m_stall = 0; m_flush = 0; m_done = 0; m_to = 0;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic model_step(input bit hz, input bit f, input bit hit, input int pc,
                              input bit rs, output int lp, output int ll, output int nl);
        lp = 0; ll = 0; nl = 0;
        if (m_state == 3) begin
            if (rs) begin m_state = 0; m_done = 0; m_to = 0; end
        end else if (f) begin
            lp = 1; ll = ALL_L; nl = (1 << FLUSH_DEPTH) - 1;
            m_flush = sat(m_flush, CMAX);
            m_state = 0;
        end else if (m_state == 2) begin
            if (hz) begin
                ll = ALL_L & ~((1 << HAZ_IDX) - 1); nl = 1 << HAZ_IDX;
                m_stall = sat(m_stall, CMAX);
            end else begin
                ll = ALL_L; nl = 1;
                if (m_drain == 0) begin m_state = 3; m_done = 1; end
                else m_drain = m_drain - 1;
            end
        end else if (!hit) begin
            m_stall = sat(m_stall, CMAX);
            if (m_state == 0) begin
                m_state = 1; m_miss = 1;
            end else begin
                m_miss = m_miss + 1;
                if (m_miss >= MISS_LIMIT) begin m_to = 1; m_done = 1; m_state = 3; end
            end
        end else if (hz) begin
            ll = ALL_L & ~((1 << HAZ_IDX) - 1); nl = 1 << HAZ_IDX;
            m_stall = sat(m_stall, CMAX);
            m_state = 0;
        end else begin
            ll = ALL_L;
            if (pc < INSTR_NUMBERS) begin
                lp = 1; m_state = 0;
            end else begin
                nl = 1; m_drain = STAGES - 2; m_state = 2;
            end
        end
    endtask

    task automatic drive(input bit hz, input bit f, input bit hit, input int pc, input bit rs);
        bus.is_hazard       = hz;
        bus.is_branch_fault = f;
        bus.is_hit          = hit;
        bus.pc_out          = WIDTH'(pc);
        bus.restart         = rs;
    endtask

    // One model-checked cycle: drive after negedge, sample 1 ns later.
    task automatic cycle(input bit hz, input bit f, input bit hit, input int pc,
                         input bit rs, input string tag);
        int lp, ll, nl, r_st, r_stall, r_flush, r_done, r_to;
        @(negedge clk);
        drive(hz, f, hit, pc, rs);
        #1;
        r_st = m_state; r_stall = m_stall; r_flush = m_flush; r_done = m_done; r_to = m_to;
        model_step(hz, f, hit, pc, rs, lp, ll, nl);
        chk({tag, ".load_pc"},      64'(bus.load_pc),      64'(lp));
        chk({tag, ".load_latch"},   64'(bus.load_latch),   64'(ll));
        chk({tag, ".nop_latch"},    64'(bus.nop_latch),    64'(nl));
        chk({tag, ".state"},        64'(bus.state),        64'(r_st));
        chk({tag, ".stall_cnt"},    64'(bus.stall_cnt),    64'(r_stall));
        chk({tag, ".flush_cnt"},    64'(bus.flush_cnt),    64'(r_flush));
        chk({tag, ".done"},         64'(bus.done),         64'(r_done));
        chk({tag, ".miss_timeout"}, 64'(bus.miss_timeout), 64'(r_to));
        $display("%s hz=%0d f=%0d hit=%0d pc=%0d rs=%0d -> st=%0d lp=%0d ll=%b nl=%b stall=%0d flush=%0d",
                 tag, hz, f, hit, pc, rs, bus.state, bus.load_pc, bus.load_latch,
                 bus.nop_latch, bus.stall_cnt, bus.flush_cnt);
    endtask

    typedef struct {
        bit hz; bit f; bit hit; int pc; bit rs;
        int lp; int ll; int nl; int st; int stall; int flush; int done;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int lp, ll, nl, fl0;

        tbl[0]  = '{0,0,1, 3,0, 1,15,0, 0,0,0,0};
        tbl[1]  = '{1,0,1, 3,0, 0,14,2, 0,0,0,0};
        tbl[2]  = '{0,0,1, 3,0, 1,15,0, 0,1,0,0};
        tbl[3]  = '{1,1,1, 3,0, 1,15,7, 0,1,0,0};
        tbl[4]  = '{0,0,1, 3,0, 1,15,0, 0,1,1,0};
        tbl[5]  = '{0,0,0, 3,0, 0, 0,0, 0,1,1,0};
        tbl[6]  = '{0,0,0, 3,0, 0, 0,0, 1,2,1,0};
        tbl[7]  = '{0,0,0, 3,0, 0, 0,0, 1,3,1,0};
        tbl[8]  = '{0,0,1, 3,0, 1,15,0, 1,4,1,0};
        tbl[9]  = '{0,0,1, 3,0, 1,15,0, 0,4,1,0};
        tbl[10] = '{0,0,1,16,0, 0,15,1, 0,4,1,0};
        tbl[11] = '{0,0,1,16,0, 0,15,1, 2,4,1,0};
        tbl[12] = '{0,0,0,16,0, 0,15,1, 2,4,1,0};
        tbl[13] = '{0,0,1,16,0, 0,15,1, 2,4,1,0};
        tbl[14] = '{0,0,1,16,0, 0,15,1, 2,4,1,0};
        tbl[15] = '{0,0,1, 3,0, 0, 0,0, 3,4,1,1};
        tbl[16] = '{1,0,0, 3,1, 0, 0,0, 3,4,1,1};
        tbl[17] = '{0,0,1, 3,0, 1,15,0, 0,4,1,0};
        tbl[18] = '{0,0,1,15,0, 1,15,0, 0,4,1,0};

        // Reset state with inputs that would otherwise drive the enables.
        drive(0, 0, 1, 3, 0);
        bus4.is_hazard = 1'b0; bus4.is_branch_fault = 1'b0; bus4.is_hit = 1'b1;
        bus4.pc_out = WIDTH'(3); bus4.restart = 1'b0;
        model_reset();
        #12;
        chk("reset.load_pc",    64'(bus.load_pc),    64'd0);
        chk("reset.load_latch", 64'(bus.load_latch), 64'd0);
        chk("reset.state",      64'(bus.state),      64'd0);
        chk("reset.stall_cnt",  64'(bus.stall_cnt),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation on the narrow-counter instance.
        bus4.is_hazard = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 1, 3, 0, $sformatf("sat[%0d]", i));
            if (i == 15) chk("sat.at16", 64'(bus4.stall_cnt), 64'd15);
        end
        @(negedge clk);
        #1;
        chk("sat.final",      64'(bus4.stall_cnt),  64'd15);
        chk("sat.load_latch", 64'(bus4.load_latch), 64'd14);
        bus4.is_hazard = 1'b0;

        // Restart both from reset for the directed table.
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i].hz, tbl[i].f, tbl[i].hit, tbl[i].pc, tbl[i].rs);
            #1;
            model_step(tbl[i].hz, tbl[i].f, tbl[i].hit, tbl[i].pc, tbl[i].rs, lp, ll, nl);
            chk($sformatf("tbl[%0d].load_pc", i),    64'(bus.load_pc),    64'(tbl[i].lp));
            chk($sformatf("tbl[%0d].load_latch", i), 64'(bus.load_latch), 64'(tbl[i].ll));
            chk($sformatf("tbl[%0d].nop_latch", i),  64'(bus.nop_latch),  64'(tbl[i].nl));
            chk($sformatf("tbl[%0d].state", i),      64'(bus.state),      64'(tbl[i].st));
            chk($sformatf("tbl[%0d].stall_cnt", i),  64'(bus.stall_cnt),  64'(tbl[i].stall));
            chk($sformatf("tbl[%0d].flush_cnt", i),  64'(bus.flush_cnt),  64'(tbl[i].flush));
            chk($sformatf("tbl[%0d].done", i),       64'(bus.done),       64'(tbl[i].done));
            $display("tbl[%0d] st=%0d lp=%0d ll=%b nl=%b stall=%0d flush=%0d done=%0d",
                     i, bus.state, bus.load_pc, bus.load_latch, bus.nop_latch,
                     bus.stall_cnt, bus.flush_cnt, bus.done);
        end

        // Back-to-back branch faults: one flush each.
        fl0 = m_flush;
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 3, 0, $sformatf("b2b[%0d]", i));
        cycle(0, 0, 1, 3, 0, "b2b_after");
        chk("b2b.flush_total", 64'(bus.flush_cnt), 64'(fl0 + 3));

        // Fault during DRAIN returns to RUN.
        cycle(0, 0, 1, 20, 0, "dfault_enter");
        cycle(1, 0, 1, 20, 0, "dfault_hazard");
        cycle(0, 1, 1, 20, 0, "dfault_flush");
        cycle(0, 0, 1, 3, 0, "dfault_run");

        // Miss timeout.
        for (int i = 0; i < MISS_LIMIT; i++) cycle(0, 0, 0, 3, 0, $sformatf("miss[%0d]", i));
        @(negedge clk);
        #1;
        chk("timeout.state", 64'(bus.state),        64'd3);
        chk("timeout.flag",  64'(bus.miss_timeout), 64'd1);
        cycle(0, 0, 0, 3, 1, "timeout_restart");
        cycle(0, 0, 1, 3, 0, "timeout_run");

        // Asynchronous reset in the middle of DRAIN.
        cycle(0, 0, 1, 16, 0, "rst_enter");
        cycle(0, 0, 1, 16, 0, "rst_drain");
        @(negedge clk);
        drive(0, 0, 1, 16, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.load_latch", 64'(bus.load_latch), 64'd0);
        chk("midrst.nop_latch",  64'(bus.nop_latch),  64'd0);
        chk("midrst.state",      64'(bus.state),      64'd0);
        chk("midrst.stall_cnt",  64'(bus.stall_cnt),  64'd0);
        chk("midrst.flush_cnt",  64'(bus.flush_cnt),  64'd0);
        chk("midrst.done",       64'(bus.done),       64'd0);
        #3;
        rst_n = 1'b1;
        cycle(0, 0, 1, 3, 0, "post_rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 1000; i++) begin
            bit hz, f, hit, rs;
            int pc;
            hz  = ($urandom % 5) == 0;
            f   = ($urandom % 8) == 0;
            hit = ($urandom % 6) != 0;
            rs  = ($urandom % 4) == 0;
            pc  = (($urandom % 10) == 0) ? int'($urandom_range(40, 16)) : int'($urandom_range(15, 0));
            cycle(hz, f, hit, pc, rs, $sformatf("rnd[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
